// File: rtl/sa_r8_pkg.sv
// Shared definitions for the radix-8 Booth output-stationary systolic array.
package sa_r8_pkg;

    function automatic int r8_groups(input int w);
        return w / 3 + 1;
    endfunction

    // One-hot partial-product magnitude selects: 1B, 2B, 3B, 4B.
    localparam logic [3:0] SEL_NONE   = 4'b0000;
    localparam logic [3:0] SEL_SINGLE = 4'b0001;
    localparam logic [3:0] SEL_DOUBLE = 4'b0010;
    localparam logic [3:0] SEL_TRIPLE = 4'b0100;
    localparam logic [3:0] SEL_QUAD   = 4'b1000;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_CHAIN = 2'd1,
        DRAIN_LOCAL = 2'd2
    } drain_sel_e;

    // The west neighbour's word always wins over the local hold register.
    function automatic drain_sel_e drain_pick(input logic chain_valid, input logic hold_valid);
        drain_sel_e sel;
        sel = DRAIN_IDLE;
        if (chain_valid) begin
            sel = DRAIN_CHAIN;
        end else if (hold_valid) begin
            sel = DRAIN_LOCAL;
        end
        return sel;
    endfunction

endpackage

// File: rtl/booth_r8_enc.sv
// Radix-8 Booth digit encoder: 4-bit overlapping window -> magnitude select + sign.
module booth_r8_enc
    import sa_r8_pkg::*;
(
    input  logic [3:0] win,
    output logic       sel_single,
    output logic       sel_double,
    output logic       sel_triple,
    output logic       sel_quad,
    output logic       neg
);

    logic [3:0] sel;

    always_comb begin
        sel = SEL_NONE;
        case (win)
            4'b0001, 4'b0010, 4'b1101, 4'b1110: sel = SEL_SINGLE;
            4'b0011, 4'b0100, 4'b1011, 4'b1100: sel = SEL_DOUBLE;
            4'b0101, 4'b0110, 4'b1001, 4'b1010: sel = SEL_TRIPLE;
            4'b0111, 4'b1000:                   sel = SEL_QUAD;
            default:                            sel = SEL_NONE;
        endcase
    end

    // 4'b1111 is digit zero, so it must not be flagged negative.
    assign neg = win[3] & ~(&win[2:0]);
    assign {sel_quad, sel_triple, sel_double, sel_single} = sel;

endmodule

// File: rtl/pe_os_r8_mac.sv
// Output-stationary systolic PE: 3-stage radix-8 Booth MAC, 1-entry result hold
// register and an eastward result drain chain.
module pe_os_r8_mac
    import sa_r8_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ACC_W    = 2*WIDTH+8,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    input  logic             acc_first,
    input  logic             acc_last,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             valid_out,
    output logic             first_out,
    output logic             last_out,
    output logic             mode_out,
    input  logic [ACC_W-1:0] res_in,
    input  logic             res_valid_in,
    output logic [ACC_W-1:0] res_out,
    output logic             res_valid_out,
    output logic             ovf_err
);

    localparam int G  = r8_groups(WIDTH);
    localparam int AX = 3*G;
    localparam int BW = WIDTH+2;
    localparam int PW = 2*WIDTH;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_out     <= '0;
            b_out     <= '0;
            valid_out <= 1'b0;
            first_out <= 1'b0;
            last_out  <= 1'b0;
            mode_out  <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            valid_out <= in_valid;
            first_out <= acc_first;
            last_out  <= acc_last;
            mode_out  <= signed_mode;
        end
    end

    // ---------------- S1: Booth encode, B and 3B ----------------
    logic [AX:0]        a_win;
    logic [BW-1:0]      b_ext;
    logic [BW-1:0]      b3_ext;
    logic [G-1:0][3:0]  enc_sel;
    logic [G-1:0]       enc_neg;

    assign a_win  = {(signed_mode ? AX'($signed(a_in)) : AX'(a_in)), 1'b0};
    assign b_ext  = signed_mode ? BW'($signed(b_in)) : BW'(b_in);
    // 3B fits BW bits when read back with the beat's own signedness.
    assign b3_ext = b_ext + (b_ext << 1);

    generate
        for (genvar gi = 0; gi < G; gi++) begin : g_enc
            booth_r8_enc u_enc (
                .win        (a_win[3*gi+3 -: 4]),
                .sel_single (enc_sel[gi][0]),
                .sel_double (enc_sel[gi][1]),
                .sel_triple (enc_sel[gi][2]),
                .sel_quad   (enc_sel[gi][3]),
                .neg        (enc_neg[gi])
            );
        end
    endgenerate

    logic [G-1:0][3:0] s1_sel_reg;
    logic [G-1:0]      s1_neg_reg;
    logic [BW-1:0]     s1_b_reg;
    logic [BW-1:0]     s1_b3_reg;
    logic              s1_valid_reg, s1_first_reg, s1_last_reg, s1_mode_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_sel_reg   <= '0;
            s1_neg_reg   <= '0;
            s1_b_reg     <= '0;
            s1_b3_reg    <= '0;
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_mode_reg  <= 1'b0;
        end else begin
            s1_sel_reg   <= enc_sel;
            s1_neg_reg   <= enc_neg;
            s1_b_reg     <= b_ext;
            s1_b3_reg    <= b3_ext;
            s1_valid_reg <= in_valid;
            s1_first_reg <= acc_first;
            s1_last_reg  <= acc_last;
            s1_mode_reg  <= signed_mode;
        end
    end

    // ---------------- S2: partial products and sum ----------------
    logic [PW-1:0] bx;
    logic [PW-1:0] b3x;
    logic [PW-1:0] pp [G];
    logic [PW-1:0] prod_next;

    assign bx  = s1_mode_reg ? PW'($signed(s1_b_reg))  : PW'(s1_b_reg);
    assign b3x = s1_mode_reg ? PW'($signed(s1_b3_reg)) : PW'(s1_b3_reg);

    generate
        for (genvar gi = 0; gi < G; gi++) begin : g_pp
            logic [PW-1:0] mag;
            assign mag = ({PW{s1_sel_reg[gi][0]}} & bx)
                       | ({PW{s1_sel_reg[gi][1]}} & (bx << 1))
                       | ({PW{s1_sel_reg[gi][2]}} & b3x)
                       | ({PW{s1_sel_reg[gi][3]}} & (bx << 2));
            assign pp[gi] = (s1_neg_reg[gi] ? (~mag + PW'(1)) : mag) << (3*gi);
        end
    endgenerate

    // Summing modulo 2^PW is exact: the true product always fits PW bits.
    always_comb begin
        prod_next = '0;
        for (int i = 0; i < G; i++) begin
            prod_next = prod_next + pp[i];
        end
    end

    logic [PW-1:0] s2_prod_reg;
    logic          s2_valid_reg, s2_first_reg, s2_last_reg, s2_mode_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s2_prod_reg  <= '0;
            s2_valid_reg <= 1'b0;
            s2_first_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_mode_reg  <= 1'b0;
        end else begin
            s2_prod_reg  <= prod_next;
            s2_valid_reg <= s1_valid_reg;
            s2_first_reg <= s1_first_reg;
            s2_last_reg  <= s1_last_reg;
            s2_mode_reg  <= s1_mode_reg;
        end
    end

    // ---------------- S3: accumulate ----------------
    logic [ACC_W-1:0] prod_x;
    logic [ACC_W-1:0] acc_reg, acc_next, acc_wrap, acc_sat;
    logic [ACC_W:0]   acc_sum;
    logic             acc_ovf;

    assign prod_x   = s2_mode_reg ? ACC_W'($signed(s2_prod_reg)) : ACC_W'(s2_prod_reg);
    assign acc_sum  = {1'b0, acc_reg} + {1'b0, prod_x};
    assign acc_wrap = acc_sum[ACC_W-1:0];

    always_comb begin
        acc_ovf = acc_sum[ACC_W];
        acc_sat = '1;
        if (s2_mode_reg) begin
            acc_ovf = (acc_reg[ACC_W-1] == prod_x[ACC_W-1]) && (acc_wrap[ACC_W-1] != acc_reg[ACC_W-1]);
            acc_sat = acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        acc_next = acc_reg;
        if (s2_valid_reg) begin
            if (s2_first_reg) begin
                acc_next = prod_x;
            end else if ((SATURATE != 0) && acc_ovf) begin
                acc_next = acc_sat;
            end else begin
                acc_next = acc_wrap;
            end
        end
    end

    // ---------------- hold register and drain ----------------
    drain_sel_e       drain_sel;
    logic             complete;
    logic             hold_free;
    logic [ACC_W-1:0] hold_reg;
    logic             hold_v_reg;

    assign drain_sel = drain_pick(res_valid_in, hold_v_reg);
    assign complete  = s2_valid_reg & s2_last_reg;
    assign hold_free = !hold_v_reg || (drain_sel == DRAIN_LOCAL);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_reg       <= '0;
            hold_reg      <= '0;
            hold_v_reg    <= 1'b0;
            res_out       <= '0;
            res_valid_out <= 1'b0;
            ovf_err       <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            case (drain_sel)
                DRAIN_CHAIN: begin
                    res_out       <= res_in;
                    res_valid_out <= 1'b1;
                end
                DRAIN_LOCAL: begin
                    res_out       <= hold_reg;
                    res_valid_out <= 1'b1;
                end
                default: res_valid_out <= 1'b0;
            endcase
            if (complete && hold_free) begin
                hold_reg   <= acc_next;
                hold_v_reg <= 1'b1;
            end else if (drain_sel == DRAIN_LOCAL) begin
                hold_v_reg <= 1'b0;
            end
            if (complete && !hold_free) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_os_r8_mac.sv
// Bench for pe_os_r8_mac: three instances (24-bit wrap, 16-bit saturate, 16-bit wrap)
// against an arithmetic reference model plus hand-computed result checks.
module tb_pe_os_r8_mac;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  a_in, b_in;
    logic        in_valid, acc_first, acc_last, signed_mode;
    logic [23:0] res_in;
    logic        res_valid_in;

    logic [7:0]  a_o [3];
    logic [7:0]  b_o [3];
    logic        v_o [3];
    logic        f_o [3];
    logic        l_o [3];
    logic        m_o [3];
    logic        rv_o [3];
    logic        ovf_o [3];
    logic [23:0] r0;
    logic [15:0] r1, r2;
    logic [31:0] r_o [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    assign r_o[0] = {8'd0, r0};
    assign r_o[1] = {16'd0, r1};
    assign r_o[2] = {16'd0, r2};

    pe_os_r8_mac #(.WIDTH(8)) u_dut0 (
        .CLK(CLK), .RST(RST), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .acc_first(acc_first), .acc_last(acc_last), .signed_mode(signed_mode),
        .a_out(a_o[0]), .b_out(b_o[0]), .valid_out(v_o[0]), .first_out(f_o[0]),
        .last_out(l_o[0]), .mode_out(m_o[0]), .res_in(res_in), .res_valid_in(res_valid_in),
        .res_out(r0), .res_valid_out(rv_o[0]), .ovf_err(ovf_o[0]));

    pe_os_r8_mac #(.WIDTH(8), .ACC_W(16), .SATURATE(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .acc_first(acc_first), .acc_last(acc_last), .signed_mode(signed_mode),
        .a_out(a_o[1]), .b_out(b_o[1]), .valid_out(v_o[1]), .first_out(f_o[1]),
        .last_out(l_o[1]), .mode_out(m_o[1]), .res_in(res_in[15:0]), .res_valid_in(res_valid_in),
        .res_out(r1), .res_valid_out(rv_o[1]), .ovf_err(ovf_o[1]));

    pe_os_r8_mac #(.WIDTH(8), .ACC_W(16), .SATURATE(0)) u_dut2 (
        .CLK(CLK), .RST(RST), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .acc_first(acc_first), .acc_last(acc_last), .signed_mode(signed_mode),
        .a_out(a_o[2]), .b_out(b_o[2]), .valid_out(v_o[2]), .first_out(f_o[2]),
        .last_out(l_o[2]), .mode_out(m_o[2]), .res_in(res_in[15:0]), .res_valid_in(res_valid_in),
        .res_out(r2), .res_valid_out(rv_o[2]), .ovf_err(ovf_o[2]));

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit     v, f, l, m;
        longint p;
    } beat_t;

    function automatic int aw_of(input int i);
        return (i == 0) ? 24 : 16;
    endfunction

    function automatic bit sat_of(input int i);
        return (i == 1);
    endfunction

    function automatic longint mask_of(input int w);
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint norm(input longint x, input int w, input bit sgn, input bit sat);
        longint span, lo, hi, r;
        span = longint'(1) << w;
        lo = sgn ? -(span / 2) : 0;
        hi = sgn ? (span / 2 - 1) : (span - 1);
        if (sat) begin
            r = (x > hi) ? hi : ((x < lo) ? lo : x);
        end else begin
            r = x & (span - 1);
            if (sgn && r > hi) r = r - span;
        end
        return r;
    endfunction

    longint m_acc [3]    = '{0, 0, 0};
    longint m_hold [3]   = '{0, 0, 0};
    longint m_res [3]    = '{0, 0, 0};
    bit     m_hold_v [3] = '{0, 0, 0};
    bit     m_rv [3]     = '{0, 0, 0};
    bit     m_ovf [3]    = '{0, 0, 0};
    beat_t  p1 = '{0, 0, 0, 0, 0};
    beat_t  p2 = '{0, 0, 0, 0, 0};
    logic [7:0] e_a = 8'd0, e_b = 8'd0;
    bit     e_v = 0, e_f = 0, e_l = 0, e_m = 0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 3; i++) begin
                m_acc[i] = 0; m_hold[i] = 0; m_res[i] = 0;
                m_hold_v[i] = 0; m_rv[i] = 0; m_ovf[i] = 0;
            end
            p1 = '{0, 0, 0, 0, 0};
            p2 = '{0, 0, 0, 0, 0};
            e_a = 8'd0; e_b = 8'd0; e_v = 0; e_f = 0; e_l = 0; e_m = 0;
        end else begin
            beat_t cur;
            cur.v = in_valid; cur.f = acc_first; cur.l = acc_last; cur.m = signed_mode;
            cur.p = signed_mode ? longint'($signed(a_in)) * longint'($signed(b_in))
                                : longint'(a_in) * longint'(b_in);
            for (int i = 0; i < 3; i++) begin
                bit was_full, emptied;
                was_full = m_hold_v[i];
                emptied  = 0;
                if (res_valid_in) begin
                    m_res[i] = longint'(res_in) & mask_of(aw_of(i));
                    m_rv[i]  = 1;
                end else if (was_full) begin
                    m_res[i] = m_hold[i];
                    m_rv[i]  = 1;
                    m_hold_v[i] = 0;
                    emptied = 1;
                end else begin
                    m_rv[i] = 0;
                end
                if (p2.v) begin
                    m_acc[i] = p2.f ? norm(p2.p, aw_of(i), p2.m, sat_of(i))
                                    : norm(m_acc[i] + p2.p, aw_of(i), p2.m, sat_of(i));
                    if (p2.l) begin
                        if (!was_full || emptied) begin
                            m_hold[i] = m_acc[i];
                            m_hold_v[i] = 1;
                        end else begin
                            m_ovf[i] = 1;
                        end
                    end
                end
            end
            p2 = p1;
            p1 = cur;
            e_a = a_in; e_b = b_in; e_v = in_valid; e_f = acc_first; e_l = acc_last; e_m = signed_mode;
        end
    end

    always @(posedge CLK) begin
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d a_out", i), longint'(a_o[i]), longint'(e_a));
            chk($sformatf("u%0d b_out", i), longint'(b_o[i]), longint'(e_b));
            chk($sformatf("u%0d framing", i), longint'({v_o[i], f_o[i], l_o[i], m_o[i]}),
                longint'({e_v, e_f, e_l, e_m}));
            chk($sformatf("u%0d res_valid_out", i), longint'(rv_o[i]), longint'(m_rv[i]));
            chk($sformatf("u%0d res_out", i), longint'(r_o[i]), m_res[i] & mask_of(aw_of(i)));
            chk($sformatf("u%0d ovf_err", i), longint'(ovf_o[i]), longint'(m_ovf[i]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #4;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input bit v, input bit f,
                        input bit l, input bit m);
        a_in = a; b_in = b; in_valid = v; acc_first = f; acc_last = l; signed_mode = m;
        tick();
    endtask

    task automatic idle();
        beat(8'd0, 8'd0, 0, 0, 0, 0);
    endtask

    task automatic wait_res();
        bit seen;
        seen = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            idle();
            seen = rv_o[0];
        end
        if (!seen) chk("wait_res timeout", 0, 1);
    endtask

    initial begin
        RST = 1'b0;
        a_in = 8'd0; b_in = 8'd0; in_valid = 0; acc_first = 0; acc_last = 0; signed_mode = 0;
        res_in = 24'd0; res_valid_in = 0;
        tick();
        tick();
        chk("reset res_valid_out", longint'(rv_o[0]), 0);
        chk("reset res_out", longint'(r_o[0]), 0);
        chk("reset ovf_err", longint'(ovf_o[0]), 0);
        RST = 1'b1;

        // 1: unsigned 255*255, single beat, out at edge 4 for one cycle
        beat(8'd255, 8'd255, 1, 1, 1, 0);
        idle(); idle(); idle();
        chk("t1 valid at edge4", longint'(rv_o[0]), 1);
        chk("t1 255*255", longint'(r_o[0]), 65025);
        idle();
        chk("t1 valid one cycle", longint'(rv_o[0]), 0);

        // 2: signed three-term sum, then a single signed beat
        beat(8'h80, 8'h80, 1, 1, 0, 1);
        beat(8'hFF, 8'd127, 1, 0, 0, 1);
        beat(8'd5, 8'hFD, 1, 0, 1, 1);
        wait_res();
        chk("t2 signed sum", longint'(r_o[0]), 16242);
        idle();
        beat(8'hFF, 8'd127, 1, 1, 1, 1);
        wait_res();
        chk("t2 -1*127", longint'(r_o[0]), 24'hFFFF81);
        idle();

        // 3: 3 x 127*127 signed: 24-bit exact, 16-bit saturate, 16-bit wrap
        beat(8'd127, 8'd127, 1, 1, 0, 1);
        beat(8'd127, 8'd127, 1, 0, 0, 1);
        beat(8'd127, 8'd127, 1, 0, 1, 1);
        wait_res();
        chk("t3 acc24", longint'(r_o[0]), 48387);
        chk("t3 sat16", longint'(r_o[1]), 32767);
        chk("t3 wrap16", longint'(r_o[2]), 16'hBD03);
        idle();

        // 5: valid 1,0,0,1,1(last); bubbles carry framing that must be ignored
        beat(8'd2, 8'd3, 1, 1, 0, 0);
        beat(8'd99, 8'd99, 0, 1, 1, 0);
        beat(8'd50, 8'd50, 0, 0, 0, 0);
        beat(8'd4, 8'd5, 1, 0, 0, 0);
        beat(8'd6, 8'd7, 1, 0, 1, 0);
        wait_res();
        chk("t5 bubble sum", longint'(r_o[0]), 68);
        idle();

        // 4a: chain stalls the local word for 3 cycles
        beat(8'd3, 8'd4, 1, 1, 1, 0);
        idle();
        res_valid_in = 1; res_in = 24'd100; idle();
        chk("t4a chain 100", longint'(r_o[0]), 100);
        res_in = 24'd101; idle();
        chk("t4a chain 101", longint'(r_o[0]), 101);
        res_in = 24'd102; idle();
        chk("t4a chain 102", longint'(r_o[0]), 102);
        res_valid_in = 0; idle();
        chk("t4a local 12", longint'(r_o[0]), 12);
        chk("t4a local valid", longint'(rv_o[0]), 1);
        chk("t4a no ovf", longint'(ovf_o[0]), 0);
        idle();

        // 4c: hold emptied and refilled on the same edge
        beat(8'd1, 8'd1, 1, 1, 1, 0);
        beat(8'd2, 8'd2, 1, 1, 1, 0);
        idle(); idle();
        chk("t4c first", longint'(r_o[0]), 1);
        idle();
        chk("t4c second", longint'(r_o[0]), 4);
        chk("t4c no ovf", longint'(ovf_o[0]), 0);
        idle();

        // 4b: second completion while the hold register is stalled
        beat(8'd5, 8'd6, 1, 1, 1, 0);
        beat(8'd7, 8'd8, 1, 1, 1, 0);
        res_valid_in = 1; res_in = 24'd200; idle();
        chk("t4b chain 200", longint'(r_o[0]), 200);
        res_in = 24'd201; idle();
        chk("t4b ovf set", longint'(ovf_o[0]), 1);
        res_in = 24'd202; idle();
        res_valid_in = 0; idle();
        chk("t4b kept first", longint'(r_o[0]), 30);
        chk("t4b ovf sticky", longint'(ovf_o[0]), 1);
        idle();

        // 6: async reset mid-cycle with a last beat in flight
        beat(8'd10, 8'd10, 1, 1, 0, 0);
        beat(8'd10, 8'd10, 1, 0, 1, 0);
        RST = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6 u%0d res_valid", i), longint'(rv_o[i]), 0);
            chk($sformatf("t6 u%0d res_out", i), longint'(r_o[i]), 0);
            chk($sformatf("t6 u%0d a_out", i), longint'(a_o[i]), 0);
            chk($sformatf("t6 u%0d valid_out", i), longint'(v_o[i]), 0);
            chk($sformatf("t6 u%0d ovf", i), longint'(ovf_o[i]), 0);
        end
        tick();
        RST = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idle();
            chk("t6 no stale result", longint'(rv_o[0]), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
